// File: rtl/tx_code_group_ctrl.sv
// PCS transmit code-group sequencer: turns ordered-set requests into one
// pre-encoding code-group per GTX_CLK, tracking position parity, idle disparity and alignment.
module tx_code_group_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    input  logic [6:0]       TX_O_SET,
    input  logic [7:0]       TXD,
    input  logic             tx_disparity,
    output logic [7:0]       tx_cg,
    output logic             tx_cg_k,
    output logic             tx_even,
    output logic             TX_OSET_indicate,
    output logic             align_err,
    output logic [CNT_W-1:0] os_count
);

    localparam logic [6:0] OS_T  = 7'd1;
    localparam logic [6:0] OS_R  = 7'd2;
    localparam logic [6:0] OS_I  = 7'd3;
    localparam logic [6:0] OS_D  = 7'd4;
    localparam logic [6:0] OS_S  = 7'd5;
    localparam logic [6:0] OS_LI = 7'd7;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    typedef enum logic {
        SEL,
        IDLE_2ND
    } state_t;

    state_t state;
    logic   idle_sel;
    logic   idle_req;

    function automatic logic is_idle(input logic [6:0] code);
        return (code == OS_I) || (code == OS_LI);
    endfunction

    // Single-group ordered sets as {K flag, octet}; unknown codes become /V/.
    function automatic logic [8:0] single_group(input logic [6:0] code,
                                                input logic [7:0] data);
        logic [8:0] g;
        case (code)
            OS_D:    g = {1'b0, data};
            OS_S:    g = {1'b1, K27_7};
            OS_T:    g = {1'b1, K29_7};
            OS_R:    g = {1'b1, K23_7};
            default: g = {1'b1, K30_7};
        endcase
        return g;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idle_req = is_idle(TX_O_SET);

    // An idle set spans two groups, so it is only consumed on its second one.
    always_comb begin
        TX_OSET_indicate = 1'b0;
        if (mr_main_reset) begin
            if (state == IDLE_2ND)
                TX_OSET_indicate = 1'b1;
            else
                TX_OSET_indicate = ~idle_req;
        end
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state     <= SEL;
            idle_sel  <= 1'b0;
            tx_cg     <= K28_5;
            tx_cg_k   <= 1'b1;
            tx_even   <= 1'b0;
            align_err <= 1'b0;
            os_count  <= '0;
        end else begin
            tx_even <= ~tx_even;
            if (TX_OSET_indicate)
                os_count <= sat_inc(os_count);
            case (state)
                SEL: begin
                    if (idle_req) begin
                        tx_cg    <= K28_5;
                        tx_cg_k  <= 1'b1;
                        idle_sel <= tx_disparity;
                        state    <= IDLE_2ND;
                        // tx_even=1 now means the comma lands in an odd slot.
                        if (tx_even)
                            align_err <= 1'b1;
                    end else begin
                        {tx_cg_k, tx_cg} <= single_group(TX_O_SET, TXD);
                    end
                end
                IDLE_2ND: begin
                    tx_cg   <= idle_sel ? D5_6 : D16_2;
                    tx_cg_k <= 1'b0;
                    state   <= SEL;
                end
                default: state <= SEL;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_code_group_ctrl.sv
// Directed bench for tx_code_group_ctrl: an ordered-set-level queue model checked
// every cycle, plus literal expectations on the code-group stream.
module tb_tx_code_group_ctrl;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk;
    logic             rst;
    logic [6:0]       code;
    logic [7:0]       txd;
    logic             disp;
    logic [7:0]       tx_cg;
    logic             tx_cg_k;
    logic             tx_even;
    logic             ind;
    logic             align_err;
    logic [CNT_W-1:0] os_count;

    int total = 0;
    int bad   = 0;

    tx_code_group_ctrl #(.CNT_W(CNT_W)) dut (
        .GTX_CLK          (clk),
        .mr_main_reset    (rst),
        .TX_O_SET         (code),
        .TXD              (txd),
        .tx_disparity     (disp),
        .tx_cg            (tx_cg),
        .tx_cg_k          (tx_cg_k),
        .tx_even          (tx_even),
        .TX_OSET_indicate (ind),
        .align_err        (align_err),
        .os_count         (os_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each ordered set expands to a list of groups; the set completes
    // (indicate) on its last group; parity is simply the group index.
    logic [8:0]       q[$];
    int               idx;
    logic [7:0]       e_cg;
    logic             e_k, e_even, e_al, e_ind;
    logic [CNT_W-1:0] e_cnt;
    logic [8:0]       g;

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            q.delete();
            idx = 0; e_cg = 8'hBC; e_k = 1'b1; e_even = 1'b0; e_al = 1'b0; e_cnt = '0;
            chk("m_ind_rst", ind, 0);
        end
        chk("m_cg", tx_cg, e_cg);
        chk("m_k", tx_cg_k, e_k);
        chk("m_even", tx_even, e_even);
        chk("m_align", align_err, e_al);
        chk("m_cnt", os_count, e_cnt);
        if (rst) begin
            if (q.size() == 0) begin
                case (code)
                    7'd3, 7'd7: begin
                        if (idx % 2 == 1) e_al = 1'b1;
                        q.push_back({1'b1, 8'hBC});
                        q.push_back({1'b0, disp ? 8'hC5 : 8'h50});
                    end
                    7'd4:    q.push_back({1'b0, txd});
                    7'd5:    q.push_back({1'b1, 8'hFB});
                    7'd1:    q.push_back({1'b1, 8'hFD});
                    7'd2:    q.push_back({1'b1, 8'hF7});
                    default: q.push_back({1'b1, 8'hFE});
                endcase
            end
            e_ind = (q.size() == 1);
            chk("m_ind", ind, e_ind);
            g = q.pop_front();
            e_k = g[8]; e_cg = g[7:0];
            e_even = (idx % 2 == 0);
            idx++;
            if (e_ind && e_cnt != CMAX) e_cnt = e_cnt + 1'b1;
        end
    end

    task automatic drive(input logic [6:0] c, input logic [7:0] d, input logic p);
        @(negedge clk);
        #1;
        code = c; txd = d; disp = p;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [6:0] f_code[10] = '{7'd3, 7'd3, 7'd5, 7'd4, 7'd4, 7'd1, 7'd2, 7'd2, 7'd3, 7'd3};
    logic [7:0] f_txd[10]  = '{8'h00, 8'h00, 8'h00, 8'h55, 8'hD5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] f_cg[10]   = '{8'hBC, 8'h50, 8'hFB, 8'h55, 8'hD5, 8'hFD, 8'hF7, 8'hF7, 8'hBC, 8'h50};

    initial begin
        rst = 1'b0; code = 7'd3; txd = 8'h00; disp = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cg", tx_cg, 8'hBC);
        chk("rst_k", tx_cg_k, 1);
        chk("rst_even", tx_even, 0);
        chk("rst_ind", ind, 0);
        chk("rst_cnt", os_count, 0);
        rst = 1'b1;

        after_edge(); chk("i1_cg", tx_cg, 8'hBC); chk("i1_even", tx_even, 1);
        after_edge(); chk("i2_cg", tx_cg, 8'h50); chk("i2_k", tx_cg_k, 0);
        after_edge(); chk("i3_cg", tx_cg, 8'hBC);
        after_edge(); chk("i4_cg", tx_cg, 8'h50);
        chk("i_cnt", os_count, 2);

        drive(7'd3, 8'h00, 1'b1); after_edge(); chk("d_bc", tx_cg, 8'hBC);
        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("d_c5", tx_cg, 8'hC5);

        for (int i = 0; i < 10; i++) begin
            drive(f_code[i], f_txd[i], 1'b0);
            after_edge();
            chk($sformatf("frame_%0d", i), tx_cg, f_cg[i]);
        end
        chk("frame_align", align_err, 0);

        drive(7'd1, 8'h00, 1'b0); after_edge(); chk("mis_t", tx_cg, 8'hFD);
        drive(7'd3, 8'h00, 1'b0); after_edge();
        chk("mis_bc", tx_cg, 8'hBC); chk("mis_odd", tx_even, 0); chk("mis_err", align_err, 1);
        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("mis_50", tx_cg, 8'h50);
        drive(7'd4, 8'h11, 1'b0); after_edge(); chk("mis_d", tx_cg, 8'h11);
        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("ok_bc", tx_cg, 8'hBC);
        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("ok_50", tx_cg, 8'h50);
        chk("err_sticky", align_err, 1);

        drive(7'd0, 8'h00, 1'b0); #1 chk("v0_ind", ind, 1);
        after_edge(); chk("v0_cg", tx_cg, 8'hFE); chk("v0_k", tx_cg_k, 1);
        drive(7'd99, 8'h00, 1'b0); #1 chk("v99_ind", ind, 1);
        after_edge(); chk("v99_cg", tx_cg, 8'hFE);

        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("r_bc", tx_cg, 8'hBC);
        @(negedge clk); #1 rst = 1'b0;
        #1;
        chk("ar_cg", tx_cg, 8'hBC); chk("ar_k", tx_cg_k, 1); chk("ar_even", tx_even, 0);
        chk("ar_ind", ind, 0); chk("ar_err", align_err, 0); chk("ar_cnt", os_count, 0);
        code = 7'd4; txd = 8'hA5;
        @(negedge clk); #1 rst = 1'b1;
        after_edge(); chk("rel_cg", tx_cg, 8'hA5); chk("rel_k", tx_cg_k, 0); chk("rel_even", tx_even, 1);
        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("rel_bc", tx_cg, 8'hBC);
        drive(7'd3, 8'h00, 1'b0); after_edge(); chk("rel_50", tx_cg, 8'h50);
        chk("rel_cnt", os_count, 2);

        for (int i = 0; i < 14; i++) drive(7'd4, 8'(i), 1'b0);
        after_edge(); chk("sat_cnt", os_count, 15);
        drive(7'd4, 8'h77, 1'b0); after_edge();
        drive(7'd4, 8'h78, 1'b0); after_edge(); chk("sat_hold", os_count, 15);

        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
